// File: rtl/riscv_div_serial_pkg.sv
// Shared defines for the serial divider.
// Operation codes and FSM state type.
package riscv_div_serial_pkg;

  localparam int DIV_W = 32;

  localparam logic [1:0] DIV_OP_DIVU = 2'b00;
  localparam logic [1:0] DIV_OP_DIV  = 2'b01;
  localparam logic [1:0] DIV_OP_REMU = 2'b10;
  localparam logic [1:0] DIV_OP_REM  = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_DIVIDE,
    DIV_FINISH
  } div_state_e;

  // bit0 of the operator selects signed arithmetic
  function automatic logic op_signed(
    input logic [1:0] op
  );
    return op[0];
  endfunction

  // bit1 of the operator selects the remainder
  function automatic logic op_rem(
    input logic [1:0] op
  );
    return op[1];
  endfunction

endpackage

// File: rtl/riscv_div_serial.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, multiplier-style EX handshake.
module riscv_div_serial
  import riscv_div_serial_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [1:0]            operator_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  multicycle_o,
  output logic                  ready_o,
  input  logic                  ex_ready_i
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(DATA_WIDTH - 1);

  div_state_e state;
  div_state_e state_n;

  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] quo_n;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] rem_n;
  logic [DATA_WIDTH-1:0] dvs;
  logic [DATA_WIDTH-1:0] dvs_n;
  logic [DATA_WIDTH-1:0] res;
  logic [DATA_WIDTH-1:0] res_n;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_n;
  logic                  rem_sel;
  logic                  rem_sel_n;
  logic                  quo_neg;
  logic                  quo_neg_n;
  logic                  rem_neg;
  logic                  rem_neg_n;

  logic                  is_signed;
  logic                  a_neg;
  logic                  b_neg;
  logic                  b_zero;
  logic [DATA_WIDTH-1:0] a_abs;
  logic [DATA_WIDTH-1:0] b_abs;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] q_step;
  logic [DATA_WIDTH-1:0] r_step;

  assign result_o = res;

  // operand conditioning: magnitudes and signs at accept
  always_comb begin
    is_signed = op_signed(operator_i);
    a_neg     = is_signed & op_a_i[DATA_WIDTH-1];
    b_neg     = is_signed & op_b_i[DATA_WIDTH-1];
    b_zero    = (op_b_i == '0);
    a_abs     = a_neg ? -op_a_i : op_a_i;
    b_abs     = b_neg ? -op_b_i : op_b_i;
  end

  // one restoring step: shift in next dividend bit, trial subtract
  always_comb begin
    shifted = {rem, quo[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[DATA_WIDTH]) begin
      r_step = diff[DATA_WIDTH-1:0];
      q_step = {quo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      r_step = shifted[DATA_WIDTH-1:0];
      q_step = {quo[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // next-state and handshake outputs
  always_comb begin
    state_n      = state;
    ready_o      = 1'b1;
    multicycle_o = 1'b0;
    unique case (state)
      DIV_IDLE: begin
        if (enable_i) begin
          ready_o = 1'b0;
          state_n = b_zero ? DIV_FINISH
                           : DIV_DIVIDE;
        end
      end
      DIV_DIVIDE: begin
        ready_o      = 1'b0;
        multicycle_o = 1'b1;
        if (cnt == '0) begin
          state_n = DIV_FINISH;
        end
      end
      DIV_FINISH: begin
        if (ex_ready_i) begin
          state_n = DIV_IDLE;
        end
      end
      default: begin
        state_n = DIV_IDLE;
      end
    endcase
  end

  // datapath next values: capture, iterate, sign-correct
  always_comb begin
    quo_n     = quo;
    rem_n     = rem;
    dvs_n     = dvs;
    res_n     = res;
    cnt_n     = cnt;
    rem_sel_n = rem_sel;
    quo_neg_n = quo_neg;
    rem_neg_n = rem_neg;
    unique case (1'b1)
      (state == DIV_IDLE) && enable_i: begin
        quo_n     = a_abs;
        rem_n     = '0;
        dvs_n     = b_abs;
        cnt_n     = CNT_LOAD;
        rem_sel_n = op_rem(operator_i);
        quo_neg_n = is_signed &
                    (op_a_i[DATA_WIDTH-1] ^
                     op_b_i[DATA_WIDTH-1]);
        rem_neg_n = a_neg;
        if (b_zero) begin
          res_n = op_rem(operator_i) ? op_a_i
                                     : '1;
        end
      end
      (state == DIV_DIVIDE): begin
        quo_n = q_step;
        rem_n = r_step;
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (rem_sel) begin
          res_n = rem_neg ? -r_step : r_step;
        end else begin
          res_n = quo_neg ? -q_step : q_step;
        end
      end
      default: begin
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      res     <= '0;
      cnt     <= '0;
      rem_sel <= 1'b0;
      quo_neg <= 1'b0;
      rem_neg <= 1'b0;
    end else begin
      quo     <= quo_n;
      rem     <= rem_n;
      dvs     <= dvs_n;
      res     <= res_n;
      cnt     <= cnt_n;
      rem_sel <= rem_sel_n;
      quo_neg <= quo_neg_n;
      rem_neg <= rem_neg_n;
    end
  end

endmodule

// File: tb/tb_riscv_div_serial.sv
// Testbench for riscv_div_serial.
// Arithmetic reference model plus per-cycle handshake checker.
module tb_riscv_div_serial;

  localparam logic [1:0] OP_DIVU = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        enable_i;
  logic [1:0]  operator_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [31:0] result_o;
  logic        multicycle_o;
  logic        ready_o;
  logic        ex_ready_i;

  int compared = 0;
  int mismatched = 0;

  // driver -> checker
  int          txn_id = 0;
  logic [31:0] exp_res = 0;
  int          exp_lat = 0;
  int          tmo_req = 0;

  // checker-owned
  int   seen_id = 0;
  int   tmo_ack = 0;
  logic act = 0;
  int   cyc = 0;
  logic pinned = 0;

  riscv_div_serial dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .operator_i   (operator_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .result_o     (result_o),
    .multicycle_o (multicycle_o),
    .ready_o      (ready_o),
    .ex_ready_i   (ex_ready_i)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] want
  );
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t",
               name, got, want, $time);
    end
  endtask

  // the single compare process
  always @(negedge clk) begin
    if (!pinned) begin
      pinned = 1;
      chk("pin_divu", model(OP_DIVU, 7, 2), 32'h3);
      chk("pin_remu", model(OP_REMU, 7, 2), 32'h1);
      chk("pin_div_neg",
          model(OP_DIV, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
      chk("pin_rem_neg",
          model(OP_REM, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
      chk("pin_rem_negb",
          model(OP_REM, 7, 32'hFFFF_FFFE), 32'h1);
      chk("pin_divu_z", model(OP_DIVU, 5, 0), 32'hFFFF_FFFF);
      chk("pin_rem_z",
          model(OP_REM, 32'hFFFF_FFFB, 0), 32'hFFFF_FFFB);
      chk("pin_ovf_div",
          model(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF),
          32'h8000_0000);
      chk("pin_ovf_rem",
          model(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
      chk("pin_divu_100", model(OP_DIVU, 100, 7), 32'd14);
    end
    if (tmo_req != tmo_ack) begin
      tmo_ack = tmo_req;
      chk("timeout", 32'd1, 32'd0);
    end
    if (!rst_n) begin
      act = 0;
      chk("rst_ready", ready_o, 1);
      chk("rst_multi", multicycle_o, 0);
      chk("rst_result", result_o, 0);
    end else begin
      if (txn_id != seen_id) begin
        seen_id = txn_id;
        act = 1;
        cyc = 0;
      end
      if (act) begin
        if (cyc < exp_lat) begin
          chk("busy_ready", ready_o, 0);
          chk("busy_multi", multicycle_o, (cyc > 0));
        end else begin
          chk("done_ready", ready_o, 1);
          chk("done_multi", multicycle_o, 0);
          chk("result", result_o, exp_res);
          if (ex_ready_i) act = 0;
        end
        cyc++;
      end else if (!enable_i) begin
        chk("idle_ready", ready_o, 1);
        chk("idle_multi", multicycle_o, 0);
      end
    end
  end

  task automatic pulse_reset();
    rst_n = 0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  // start an operation in the current IDLE cycle
  task automatic start(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    enable_i   = 1;
    operator_i = op;
    op_a_i     = a;
    op_b_i     = b;
    ex_ready_i = 1'($urandom_range(0, 1));
    exp_res    = model(op, a, b);
    exp_lat    = (b == 0) ? 1 : 33;
    txn_id++;
    @(posedge clk); #2;
    enable_i   = 0;
    operator_i = 2'($urandom);
    op_a_i     = $urandom;
    op_b_i     = $urandom;
  endtask

  task automatic run(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          stall
  );
    int c;
    int l;
    l = (b == 0) ? 1 : 33;
    start(op, a, b);
    c = 1;
    while (act && c < l + stall + 60) begin
      if (c < l) ex_ready_i = 1'($urandom_range(0, 1));
      else ex_ready_i = (c >= l + stall);
      @(posedge clk); #2;
      c++;
    end
    ex_ready_i = 0;
    if (act) begin
      tmo_req++;
      pulse_reset();
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      5: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n      = 0;
    enable_i   = 0;
    operator_i = 0;
    op_a_i     = 0;
    op_b_i     = 0;
    ex_ready_i = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #2;

    run(OP_DIVU, 7, 2, 0);
    run(OP_REMU, 7, 2, 0);
    run(OP_DIV, 32'hFFFF_FFF9, 2, 1);
    run(OP_REM, 32'hFFFF_FFF9, 2, 0);
    run(OP_REM, 7, 32'hFFFF_FFFE, 0);
    run(OP_DIVU, 5, 0, 0);
    run(OP_REM, 32'hFFFF_FFFB, 0, 2);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(OP_DIVU, 32'hDEAD_BEEF, 3, 5);
    run(OP_DIVU, 100, 7, 0);

    // reset at DIVIDE iteration 10
    start(OP_DIVU, 32'h1234_5678, 9);
    repeat (9) begin
      @(posedge clk); #2;
    end
    pulse_reset();
    run(OP_DIVU, 32'hFFFF_FFFF, 1, 0);

    for (int i = 0; i < 300; i++) begin
      run(2'($urandom), rnd_operand(), rnd_operand(),
          $urandom_range(0, 3));
    end

    @(posedge clk); #2;
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
